// File: rtl/hilo_unit.sv
// HI/LO register pair and MULT sequencer behind the Booth radix-4 multiplier.
// Optional multiply-accumulate capture is enabled by defining HILO_MADD_EN.
module hilo_unit #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        acc,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mf_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] prod,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic        wr_err
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mul_a_q;
  logic [DATA_W-1:0]   mul_b_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                busy_q;
  logic                done_q;
  logic                wr_err_q;
  logic [2*DATA_W-1:0] capt_val;

`ifdef HILO_MADD_EN
  logic acc_q;

  // Accumulate adds the product to whatever HI/LO hold at the capture edge.
  assign capt_val = acc_q ? ({hi_q, lo_q} + prod) : prod;
`else
  logic unused_acc;

  assign unused_acc = acc;
  assign capt_val   = prod;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            mul_a_q <= src_a;
            mul_b_q <= src_b;
            cnt_q   <= CNT_W'(MUL_LAT);
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
`ifdef HILO_MADD_EN
            acc_q   <= acc;
`endif
          end
        end
        ST_WAIT: begin
          if (mthi || mtlo) wr_err_q <= 1'b1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          if (mthi || mtlo) wr_err_q <= 1'b1;
          {hi_q, lo_q} <= capt_val;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The CPU must hold any HI/LO-touching instruction while a multiply is in flight.
  assign stall  = busy_q & (start | mf_req | mthi | mtlo);

  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed cases followed by randomized traffic
// against a cycle-level behavioural model of HI/LO and a pipelined multiplier model.
module tb_hilo_unit;

  localparam int unsigned MUL_LAT = 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, acc, mthi, mtlo, mf_req;
  logic [31:0] src_a, src_b, wdata;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] prod;
  logic        busy, done, stall, wr_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [63:0] sb_q[$];

  // Model state
  logic [31:0] m_hi, m_lo, m_ma, m_mb;
  logic [63:0] m_pend;
  logic        m_wr_err, m_done;
  int          m_busy_left;

  always #5 clock = ~clock;

  hilo_unit #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .acc(acc),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .mf_req(mf_req), .mul_a(mul_a), .mul_b(mul_b),
    .prod(prod), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall(stall), .wr_err(wr_err)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Booth multiplier stand-in: MUL_LAT register stages after the operand registers.
  logic [63:0] pipe [MUL_LAT];
  always @(posedge clock) begin
    pipe[0] <= smul(mul_a, mul_b);
    for (int i = 1; i < int'(MUL_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign prod = pipe[MUL_LAT-1];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending capture.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_spurious: done=1 with no multiply pending (t=%0t)", $time);
      end else begin
        check("capture_hilo", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_ma = '0; m_mb = '0; m_pend = '0;
    m_wr_err = 1'b0; m_done = 1'b0; m_busy_left = 0;
    sb_q.delete();
  endtask

  // One clock of stimulus; called right after a falling edge.
  task automatic step(input logic st, input logic ac, input logic [31:0] a, input logic [31:0] b,
                      input logic hw, input logic lw, input logic [31:0] wd, input logic mf);
    logic [63:0] p;
    check("hi",     64'(hi),     64'(m_hi));
    check("lo",     64'(lo),     64'(m_lo));
    check("busy",   64'(busy),   64'(m_busy_left > 0));
    check("done",   64'(done),   64'(m_done));
    check("mul_a",  64'(mul_a),  64'(m_ma));
    check("mul_b",  64'(mul_b),  64'(m_mb));
    check("wr_err", 64'(wr_err), 64'(m_wr_err));
    start = st; acc = ac; src_a = a; src_b = b;
    mthi = hw; mtlo = lw; wdata = wd; mf_req = mf;
    #1;
    check("stall", 64'(stall), 64'((m_busy_left > 0) && (st || mf || hw || lw)));
    m_done = 1'b0;
    if (m_busy_left > 0) begin
      if (hw || lw) m_wr_err = 1'b1;
      m_busy_left--;
      if (m_busy_left == 0) begin
        {m_hi, m_lo} = m_pend;
        m_done = 1'b1;
      end
    end else begin
      if (hw) m_hi = wd;
      if (lw) m_lo = wd;
      if (st) begin
        m_ma = a;
        m_mb = b;
        m_busy_left = int'(MUL_LAT) + 1;
        p = smul(a, b);
        m_pend = p;
`ifdef HILO_MADD_EN
        if (ac) m_pend = {m_hi, m_lo} + p;
`endif
        sb_q.push_back(m_pend);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, 0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    start = 0; acc = 0; mthi = 0; mtlo = 0; mf_req = 0;
    src_a = '0; src_b = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_hi",     64'(hi),     64'h0);
    check("rst_lo",     64'(lo),     64'h0);
    check("rst_busy",   64'(busy),   64'h0);
    check("rst_done",   64'(done),   64'h0);
    check("rst_wr_err", 64'(wr_err), 64'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic MULT 6*7
    step(1, 0, 32'd6, 32'd7, 0, 0, '0, 0);
    idle(2);
    check("mult42_lo", 64'(lo), 64'h2A);
    check("mult42_hi", 64'(hi), 64'h0);

    // Negative product
    step(1, 0, 32'hFFFF_FFFF, 32'd2, 0, 0, '0, 0);
    idle(2);
    check("neg_hi", 64'(hi), 64'hFFFF_FFFF);
    check("neg_lo", 64'(lo), 64'hFFFF_FFFE);

    // Conflicts while busy
    step(1, 0, 32'd3, 32'd4, 0, 0, '0, 0);
    step(1, 0, 32'd9, 32'd9, 1, 0, 32'h55, 0);
    step(0, 0, '0, '0, 0, 0, '0, 1);
    idle(1);
    check("conf_hi", 64'(hi), 64'h0);
    check("conf_lo", 64'(lo), 64'd12);
    idle(2);
    check("wr_err_sticky", 64'(wr_err), 64'h1);

    // IDLE write of both, then back-to-back start
    step(0, 0, '0, '0, 1, 1, 32'h1234_5678, 0);
    step(1, 0, 32'd3, 32'd5, 0, 0, '0, 0);
    check("mt_both_hi", 64'(hi), 64'h1234_5678);
    check("mt_both_lo", 64'(lo), 64'h1234_5678);
    idle(2);
    check("b2b_lo", 64'(lo), 64'd15);
    check("b2b_hi", 64'(hi), 64'h0);

    // Accumulate with carry across LO->HI
    step(0, 0, '0, '0, 1, 0, 32'h0, 0);
    step(0, 0, '0, '0, 0, 1, 32'hFFFF_FFFF, 0);
    step(1, 1, 32'd1, 32'd1, 0, 0, '0, 0);
    idle(2);
`ifdef HILO_MADD_EN
    check("madd_hi", 64'(hi), 64'h1);
    check("madd_lo", 64'(lo), 64'h0);
`else
    check("madd_hi", 64'(hi), 64'h0);
    check("madd_lo", 64'(lo), 64'h1);
`endif

    // Start presented at the capture edge is ignored, then accepted in IDLE
    step(1, 0, 32'd2, 32'd3, 0, 0, '0, 0);
    step(0, 0, '0, '0, 0, 0, '0, 0);
    step(1, 0, 32'd10, 32'd10, 0, 0, '0, 0);
    step(1, 0, 32'd11, 32'd11, 1, 0, 32'hABCD, 0);
    idle(3);
    check("late_start_lo", 64'(lo), 64'd121);

    // Reset in the middle of a multiply
    step(1, 0, 32'd100, 32'd100, 0, 0, '0, 0);
    #2;
    reset_n = 1'b0;
    start = 0; acc = 0; mthi = 0; mtlo = 0; mf_req = 0;
    #1;
    check("midrst_hi",   64'(hi),   64'h0);
    check("midrst_lo",   64'(lo),   64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rand_op(), rand_op(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 3) == 0);
    end
    idle(int'(MUL_LAT) + 3);
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
